// File: rtl/sequenciador_dampers_if.sv
// Damper sequencer bus: requests and limit switches in, actuator commands and fault status out.
// Optional VENTILACAO_EMERGENCIA_EN adds the emergencia level input.
interface sequenciador_dampers_if #(
  parameter int N = 6
) ();
  logic [N-1:0] req;
  logic [N-1:0] fim_curso;
  logic         ack_falha;
  logic [N-1:0] damper_cmd;
  logic         ocupado;
  logic [N-1:0] falha;
  logic         alarmeSonoroVentilacao;
`ifdef VENTILACAO_EMERGENCIA_EN
  logic         emergencia;

  modport master (
    output req, fim_curso, ack_falha, emergencia,
    input  damper_cmd, ocupado, falha, alarmeSonoroVentilacao
  );
  modport slave (
    input  req, fim_curso, ack_falha, emergencia,
    output damper_cmd, ocupado, falha, alarmeSonoroVentilacao
  );
`else
  modport master (
    output req, fim_curso, ack_falha,
    input  damper_cmd, ocupado, falha, alarmeSonoroVentilacao
  );
  modport slave (
    input  req, fim_curso, ack_falha,
    output damper_cmd, ocupado, falha, alarmeSonoroVentilacao
  );
`endif
endinterface

// File: rtl/sequenciador_dampers.sv
// Moves one damper at a time (lowest index first), supervises limit switch with timeout, settles after each move.
// Command changes one cycle after a pending request is seen; VENTILACAO_EMERGENCIA_EN forces all dampers open.
module sequenciador_dampers #(
  parameter int N_DAMPERS   = 6,
  parameter int TIMEOUT_CYC = 1000,
  parameter int SETTLE_CYC  = 50,
  parameter int CNT_W       = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  sequenciador_dampers_if.slave io_bus
);

  localparam int SEL_W = (N_DAMPERS > 1) ? $clog2(N_DAMPERS) : 1;

  typedef enum logic [1:0] {IDLE, MOVE, SETTLE} state_t;

  state_t               r_state, w_state_nx;
  logic [SEL_W-1:0]     r_sel, w_sel_nx, w_win;
  logic [CNT_W-1:0]     r_timer, w_timer_nx;
  logic [N_DAMPERS-1:0] r_cmd, w_cmd_nx;
  logic [N_DAMPERS-1:0] r_falha, w_falha_nx;
  logic [N_DAMPERS-1:0] w_pending;
  logic                 w_any;
  logic                 w_match;

  // Faulted dampers are frozen: they never count as pending.
  assign w_pending = (io_bus.req ^ r_cmd) & ~r_falha;
  assign w_any     = |w_pending;
  assign w_match   = (io_bus.fim_curso[r_sel] == r_cmd[r_sel]);

  always_comb begin
    w_win = '0;
    for (int i = N_DAMPERS - 1; i >= 0; i--) begin
      if (w_pending[i]) begin
        w_win = SEL_W'(i);
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_sel_nx   = r_sel;
    w_timer_nx = r_timer;
    w_cmd_nx   = r_cmd;
    w_falha_nx = io_bus.ack_falha ? '0 : r_falha;

    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_sel_nx        = w_win;
          w_cmd_nx[w_win] = ~r_cmd[w_win];
          w_timer_nx      = '0;
          w_state_nx      = MOVE;
        end
      end
      MOVE: begin
        w_timer_nx = r_timer + CNT_W'(1);
        // A match on the last allowed cycle still counts as success.
        if (w_match) begin
          w_timer_nx = '0;
          w_state_nx = SETTLE;
        end else if (r_timer == CNT_W'(TIMEOUT_CYC - 1)) begin
          w_falha_nx[r_sel] = 1'b1;
          w_timer_nx        = '0;
          w_state_nx        = IDLE;
        end
      end
      SETTLE: begin
        w_timer_nx = r_timer + CNT_W'(1);
        if (r_timer == CNT_W'(SETTLE_CYC - 1)) begin
          w_timer_nx = '0;
          w_state_nx = IDLE;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_timer_nx = '0;
      end
    endcase

`ifdef VENTILACAO_EMERGENCIA_EN
    if (io_bus.emergencia) begin
      w_cmd_nx   = '1;
      w_timer_nx = '0;
      w_state_nx = IDLE;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_timer <= '0;
      r_cmd   <= '0;
      r_falha <= '0;
    end else begin
      r_state <= w_state_nx;
      r_sel   <= w_sel_nx;
      r_timer <= w_timer_nx;
      r_cmd   <= w_cmd_nx;
      r_falha <= w_falha_nx;
    end
  end

  assign io_bus.damper_cmd = r_cmd;
  assign io_bus.falha      = r_falha;
  assign io_bus.ocupado    = (r_state != IDLE);
`ifdef VENTILACAO_EMERGENCIA_EN
  assign io_bus.alarmeSonoroVentilacao = (|r_falha) | io_bus.emergencia;
`else
  assign io_bus.alarmeSonoroVentilacao = |r_falha;
`endif

endmodule

// File: tb/tb_sequenciador_dampers.sv
// Directed bench for sequenciador_dampers with TIMEOUT_CYC = 8, SETTLE_CYC = 4.
module tb_sequenciador_dampers;

  localparam int N = 6;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   busy;

  sequenciador_dampers_if #(.N(N)) bus ();

  sequenciador_dampers #(
    .N_DAMPERS  (N),
    .TIMEOUT_CYC(8),
    .SETTLE_CYC (4),
    .CNT_W      (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (bus.ocupado === 1'b1 && k < 100) begin
      tick();
      k++;
    end
    check(tag, 32'(bus.ocupado), 32'd0);
  endtask

  initial begin
    bus.req       = '0;
    bus.fim_curso = '0;
    bus.ack_falha = 1'b0;
`ifdef VENTILACAO_EMERGENCIA_EN
    bus.emergencia = 1'b0;
`endif
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    check("rst_cmd",   32'(bus.damper_cmd), 32'h00);
    check("rst_falha", 32'(bus.falha), 32'h00);
    check("rst_busy",  32'(bus.ocupado), 32'd0);
    check("rst_alarm", 32'(bus.alarmeSonoroVentilacao), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_cmd", 32'(bus.damper_cmd), 32'h00);

    // 1: single damper, 3 MOVE + 4 SETTLE cycles
    bus.req = 6'b000100;
    tick();
    check("t1_cmd", 32'(bus.damper_cmd), 32'h04);
    check("t1_busy_start", 32'(bus.ocupado), 32'd1);
    tick();
    tick();
    bus.fim_curso = 6'b000100;
    busy = 3;
    tick();
    while (bus.ocupado === 1'b1 && busy < 60) begin
      busy++;
      tick();
    end
    check("t1_busy_cycles", 32'(busy), 32'd7);
    check("t1_falha", 32'(bus.falha), 32'h00);

    // 2: priority, bit0 before bit5
    bus.req = 6'b100101;
    tick();
    check("t2_first_bit0", 32'(bus.damper_cmd), 32'h05);
    tick();
    bus.fim_curso = 6'b000101;
    tick();
    tick();
    tick();
    tick();
    check("t2_settle_hold", 32'(bus.damper_cmd), 32'h05);
    check("t2_settle_busy", 32'(bus.ocupado), 32'd1);
    tick();
    check("t2_idle_gap", 32'(bus.ocupado), 32'd0);
    check("t2_idle_cmd", 32'(bus.damper_cmd), 32'h05);
    tick();
    check("t2_second_bit5", 32'(bus.damper_cmd), 32'h25);
    tick();
    bus.fim_curso = 6'b100101;
    wait_idle("t2_done");
    check("t2_final_cmd", 32'(bus.damper_cmd), 32'h25);

    // 3: timeout on damper 1, exclusion while faulted, ack
    bus.req = 6'b100111;
    tick();
    check("t3_cmd", 32'(bus.damper_cmd), 32'h27);
    repeat (7) tick();
    check("t3_no_fault_yet", 32'(bus.falha), 32'h00);
    check("t3_still_moving", 32'(bus.ocupado), 32'd1);
    tick();
    check("t3_falha", 32'(bus.falha), 32'h02);
    check("t3_alarm", 32'(bus.alarmeSonoroVentilacao), 32'd1);
    check("t3_cmd_kept", 32'(bus.damper_cmd), 32'h27);
    check("t3_idle", 32'(bus.ocupado), 32'd0);
    bus.req = 6'b100101;
    tick();
    tick();
    check("t3_frozen_cmd", 32'(bus.damper_cmd), 32'h27);
    check("t3_frozen_idle", 32'(bus.ocupado), 32'd0);
    bus.ack_falha = 1'b1;
    tick();
    bus.ack_falha = 1'b0;
    check("t3_ack_falha", 32'(bus.falha), 32'h00);
    check("t3_ack_alarm", 32'(bus.alarmeSonoroVentilacao), 32'd0);
    tick();
    check("t3_close_cmd", 32'(bus.damper_cmd), 32'h25);
    check("t3_close_busy", 32'(bus.ocupado), 32'd1);
    wait_idle("t3_done");

    // 4: reversal during MOVE
    bus.req = 6'b101101;
    tick();
    check("t4_open_cmd", 32'(bus.damper_cmd), 32'h2D);
    tick();
    bus.req = 6'b100101;
    tick();
    check("t4_move_cmd", 32'(bus.damper_cmd), 32'h2D);
    check("t4_move_busy", 32'(bus.ocupado), 32'd1);
    bus.fim_curso = 6'b101101;
    tick();
    wait_idle("t4_first_done");
    check("t4_opened", 32'(bus.damper_cmd), 32'h2D);
    tick();
    check("t4_reverse_cmd", 32'(bus.damper_cmd), 32'h25);
    check("t4_reverse_busy", 32'(bus.ocupado), 32'd1);
    bus.fim_curso = 6'b100101;
    wait_idle("t4_second_done");
    check("t4_final_cmd", 32'(bus.damper_cmd), 32'h25);

    // 5: asynchronous reset mid-MOVE
    bus.req = 6'b100111;
    tick();
    check("t5_moving", 32'(bus.ocupado), 32'd1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_cmd",  32'(bus.damper_cmd), 32'h00);
    check("t5_async_busy", 32'(bus.ocupado), 32'd0);
    check("t5_async_falha", 32'(bus.falha), 32'h00);
    bus.req       = '0;
    bus.fim_curso = '0;
    #2 rst_n = 1'b1;
    tick();
    check("t5_after_cmd", 32'(bus.damper_cmd), 32'h00);
    check("t5_after_busy", 32'(bus.ocupado), 32'd0);

`ifdef VENTILACAO_EMERGENCIA_EN
    // 6: emergency open-all, then sequential close from bit 0
    bus.emergencia = 1'b1;
    tick();
    check("t6_all_open", 32'(bus.damper_cmd), 32'h3F);
    check("t6_alarm", 32'(bus.alarmeSonoroVentilacao), 32'd1);
    check("t6_idle", 32'(bus.ocupado), 32'd0);
    bus.emergencia = 1'b0;
    bus.fim_curso  = 6'b111111;
    tick();
    check("t6_close_bit0", 32'(bus.damper_cmd), 32'h3E);
    check("t6_alarm_off", 32'(bus.alarmeSonoroVentilacao), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sequenciador_dampers.md
Name: sequenciador_dampers

Overview:
- Sequences the ventilation dampers between the containment zones: reactor/SR tube, S3/SR, S2/S3, S1/S2, S3/SS and SS/SC.
- Takes per-damper open/close requests from the pressure-comparison logic and moves one damper at a time, because the pneumatic actuator supply is shared.
- Supervises each damper's limit switch, applies a settling interval after every movement, and latches a fault when a damper fails to reach position.

Parameters:
N_DAMPERS, 6, number of dampers; index 0 = RSR, 1 = S3SR, 2 = S23, 3 = S12, 4 = S3SS, 5 = SSSC.
TIMEOUT_CYC, 1000, maximum cycles allowed for the limit switch to match the command.
SETTLE_CYC, 50, pause cycles after a successful movement before the next one may start.
CNT_W, 16, width of the shared timer; must hold max(TIMEOUT_CYC, SETTLE_CYC).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  N_DAMPERS  requested damper state (1 = open), level.
fim_curso  input  N_DAMPERS  limit switch, 1 = damper physically open.
ack_falha  input  1  single-cycle pulse; clears all latched faults.
damper_cmd  output  N_DAMPERS  registered actuator command, 1 = open.
ocupado  output  1  high in MOVE or SETTLE.
falha  output  N_DAMPERS  latched per-damper fault.
alarmeSonoroVentilacao  output  1  high while any falha bit is set.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - damper_cmd = 0, falha = 0, timer = 0.
  - ocupado = 0, alarmeSonoroVentilacao = 0.
  - Reset mid-movement abandons the movement immediately.
- Pending damper i: req[i] != damper_cmd[i] and falha[i] = 0.
- Selection: fixed priority, lowest pending index wins, so reactor-side dampers go first.
- IDLE: on the first edge with any damper pending:
  - sel <= winner index;
  - damper_cmd[sel] toggles;
  - timer <= 0;
  - state <= MOVE.
  - The command therefore changes one cycle after the request is seen.
- MOVE: every cycle timer increments.
  - If fim_curso[sel] == damper_cmd[sel]: state <= SETTLE, timer <= 0.
  - Else if timer == TIMEOUT_CYC-1: falha[sel] <= 1, state <= IDLE. damper_cmd[sel] keeps the commanded value.
  - The match check takes precedence over timeout on the same cycle.
- SETTLE: timer increments; at timer == SETTLE_CYC-1, state <= IDLE.
- req changes during MOVE or SETTLE are not acted on until the return to IDLE, then re-evaluated. A reverted request produces a reverse movement.
- A damper with falha set is excluded from selection; its damper_cmd is frozen.
- ack_falha clears all falha bits on the next edge.
  - If ack_falha coincides with a timeout, the new fault wins for that index; other bits clear.
- alarmeSonoroVentilacao is combinational OR of falha.
- ocupado = (state != IDLE).
- At most one damper_cmd bit changes per movement. Two cycles minimum separate consecutive movements: MOVE lasts at least 1 cycle, SETTLE lasts SETTLE_CYC cycles.
- Limit-switch disagreement on a damper that is not selected is ignored.

Optional Feature:
VENTILACAO_EMERGENCIA_EN
- Defined:
  - Adds input port emergencia (1 bit, level).
  - While emergencia = 1: damper_cmd <= all ones on the next edge (faulted dampers included), state <= IDLE, timer <= 0.
  - alarmeSonoroVentilacao is forced high.
  - Sequencing resumes from IDLE when emergencia falls; dampers then close one at a time per req.
- Not defined: port absent; behaviour exactly as above.

Test Plan:
Bench parameters: TIMEOUT_CYC = 8, SETTLE_CYC = 4.
1. Single damper: after reset, req = 6'b000100, fim_curso[2] follows cmd after 3 cycles -> damper_cmd = 6'b000100 one cycle after req; ocupado high for 3 MOVE + 4 SETTLE cycles; falha = 0.
2. Priority: req = 6'b100001 applied at once, limit switches follow after 2 cycles -> bit0 opens first; bit5 opens only after bit0's SETTLE completes; never two cmd bits changing in one movement.
3. Timeout: req = 6'b000010, fim_curso stuck 0 -> after 8 MOVE cycles falha = 6'b000010, alarm = 1, damper_cmd[1] stays 1. ack_falha pulse -> falha = 0, alarm = 0.
4. Request reversal mid-move: open damper 3, drop req[3] during MOVE -> movement completes and settles, then damper 3 closes in a second movement.
5. Async reset mid-MOVE: assert rst_n = 0 between edges -> damper_cmd, falha and ocupado are 0 immediately, without waiting for a clock.
6. With VENTILACAO_EMERGENCIA_EN: emergencia = 1 while sequencing -> damper_cmd = 6'b111111 on next edge, alarm = 1. Release with req = 0 -> dampers close individually, bit 0 first.
